// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings and BCD constants for the microwave timer
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;
    localparam int         CNT_W         = 3;

    // Keypad codes above 9 (e.g. '*' or '#') are not digits.
    function automatic logic digit_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_time_reg.sv
// rtl/bcd_time_reg.sv - four-digit BCD MM:SS register with shift-in and countdown
//
// Ports:
//   clk_i, resetn_i          clock, synchronous active-low reset
//   shift_en_i, digit_i      shift digit_i in at sec_ones, everything moves left
//   dec_en_i                 decrement MM:SS by one second
//   zero_clr_i               clear all digits (highest priority)
//   min_tens_o..sec_ones_o   current digits
//   is_zero_o                register holds 00:00
//   next_is_zero_o           a decrement now would produce 00:00
module bcd_time_reg
    import timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       shift_en_i,
    input  logic [3:0] digit_i,
    input  logic       dec_en_i,
    input  logic       zero_clr_i,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       is_zero_o,
    output logic       next_is_zero_o
);

    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_dec, mo_dec, st_dec, so_dec;

    // Seconds 60-99 are legal entries, so only the 00 case borrows from minutes.
    always_comb begin
        mt_dec = mt_q;
        mo_dec = mo_q;
        st_dec = st_q;
        so_dec = so_q;
        if (so_q != 4'd0) begin
            so_dec = so_q - 4'd1;
        end else if (st_q != 4'd0) begin
            st_dec = st_q - 4'd1;
            so_dec = BCD_MAX;
        end else begin
            st_dec = SEC_TENS_WRAP;
            so_dec = BCD_MAX;
            if (mo_q != 4'd0) begin
                mo_dec = mo_q - 4'd1;
            end else begin
                mo_dec = BCD_MAX;
                mt_dec = mt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i || zero_clr_i) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
        end else if (shift_en_i) begin
            mt_q <= mo_q;
            mo_q <= st_q;
            st_q <= so_q;
            so_q <= digit_i;
        end else if (dec_en_i) begin
            mt_q <= mt_dec;
            mo_q <= mo_dec;
            st_q <= st_dec;
            so_q <= so_dec;
        end
    end

    assign min_tens_o     = mt_q;
    assign min_ones_o     = mo_q;
    assign sec_tens_o     = st_q;
    assign sec_ones_o     = so_q;
    assign is_zero_o      = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
    // Only 00:01 decrements to 00:00.
    assign next_is_zero_o = ({mt_q, mo_q, st_q, so_q} == 16'h0001);

endmodule

// File: rtl/timer_entry_ctrl.sv
// rtl/timer_entry_ctrl.sv - microwave timer entry, countdown FSM and magnetron enable
//
// Ports:
//   clk, clr                 clock, synchronous active-low reset
//   key_valid, key_digit     keypad digit strobe and value (0-9 accepted)
//   start, stop_clear        start/resume and pause/cancel pulses
//   door_open                door level, 1 = open
//   sec_tick                 one pulse per second
//   min_tens..sec_ones       BCD MM:SS display digits
//   magnetron_on, done       high in RUN / DONE respectively
//   state                    current FSM state
module timer_entry_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DONE_HOLD  = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_open,
    input  logic       sec_tick,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_DIGITS);
    localparam logic [2:0]       HOLD_LIM = 3'(DONE_HOLD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       hold_q, hold_d;
    logic             shift_en, dec_en, zero_clr;
    logic             is_zero, next_is_zero;
    logic             key_ok;

    assign key_ok = key_valid && digit_ok(key_digit) && (cnt_q < CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        shift_en = 1'b0;
        dec_en   = 1'b0;
        zero_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (stop_clear) begin
                    zero_clr = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (start) begin
                    // A refused start still masks a key in the same cycle.
                    if (!is_zero && !door_open) begin
                        state_d = ST_RUN;
                    end
                end else if (key_ok) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = ST_ENTRY;
                end
            end
            ST_RUN: begin
                // Pausing swallows a coincident tick so the display never skips.
                if (door_open || stop_clear) begin
                    state_d = ST_PAUSE;
                end else if (sec_tick) begin
                    dec_en = 1'b1;
                    if (next_is_zero) begin
                        state_d = ST_DONE;
                        hold_d  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    zero_clr = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (start && !door_open) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (key_valid || start || stop_clear) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sec_tick) begin
                    if (hold_q + 3'd1 == HOLD_LIM) begin
                        hold_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    bcd_time_reg u_time (
        .clk_i          (clk),
        .resetn_i       (clr),
        .shift_en_i     (shift_en),
        .digit_i        (key_digit),
        .dec_en_i       (dec_en),
        .zero_clr_i     (zero_clr),
        .min_tens_o     (min_tens),
        .min_ones_o     (min_ones),
        .sec_tens_o     (sec_tens),
        .sec_ones_o     (sec_ones),
        .is_zero_o      (is_zero),
        .next_is_zero_o (next_is_zero)
    );

    assign state        = state_q;
    assign magnetron_on = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// tb/tb_timer_entry_ctrl.sv - self-checking bench for timer_entry_ctrl
module tb_timer_entry_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_open = 1'b0;
    logic       sec_tick = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       magnetron_on, done;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: digits as plain integers, time handled as minutes/seconds.
    int m_state = 0;
    int m_dig[4] = '{0, 0, 0, 0};   // [3]=min_tens ... [0]=sec_ones
    int m_cnt = 0;
    int m_hold = 0;
    localparam int HOLD = 3;

    timer_entry_ctrl #(.NUM_DIGITS(4), .DONE_HOLD(HOLD)) dut (
        .clk          (clk),
        .clr          (clr),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_open    (door_open),
        .sec_tick     (sec_tick),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .magnetron_on (magnetron_on),
        .done         (done),
        .state        (state)
    );

    always #5 clk = ~clk;

    // {state, magnetron_on, done, MM:SS}
    function automatic logic [20:0] snap();
        return {state, magnetron_on, done, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [20:0] model_vec();
        logic [2:0] s;
        s = 3'(m_state);
        return {s, (m_state == 2), (m_state == 4),
                4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    endfunction

    function automatic logic [20:0] ev(input int s, input logic [15:0] t);
        return {3'(s), (s == 2), (s == 4), t};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        int mm, ss;
        bit nz;
        nz = (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0;
        if (!clr) begin
            model_clear();
            m_state = 0;
            m_hold = 0;
        end else begin
            case (m_state)
                0, 1: begin
                    if (stop_clear) begin
                        model_clear();
                        m_state = 0;
                    end else if (start) begin
                        if (nz && !door_open) m_state = 2;
                    end else if (key_valid && key_digit <= 9 && m_cnt < 4) begin
                        for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
                        m_dig[0] = key_digit;
                        m_cnt++;
                        m_state = 1;
                    end
                end
                2: begin
                    if (door_open || stop_clear) begin
                        m_state = 3;
                    end else if (sec_tick) begin
                        mm = m_dig[3] * 10 + m_dig[2];
                        ss = m_dig[1] * 10 + m_dig[0];
                        if (ss > 0) ss--;
                        else begin
                            mm--;
                            ss = 59;
                        end
                        m_dig[3] = mm / 10; m_dig[2] = mm % 10;
                        m_dig[1] = ss / 10; m_dig[0] = ss % 10;
                        if (mm == 0 && ss == 0) begin
                            m_state = 4;
                            m_hold = 0;
                        end
                    end
                end
                3: begin
                    if (stop_clear) begin
                        model_clear();
                        m_state = 0;
                    end else if (start && !door_open) m_state = 2;
                end
                4: begin
                    if (key_valid || start || stop_clear) begin
                        m_state = 0;
                        m_cnt = 0;
                    end else if (sec_tick) begin
                        m_hold++;
                        if (m_hold == HOLD) begin
                            m_state = 0;
                            m_cnt = 0;
                            m_hold = 0;
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kd, input logic st,
                        input logic sc, input logic dr, input logic tk);
        key_valid = kv; key_digit = kd; start = st;
        stop_clear = sc; door_open = dr; sec_tick = tk;
        model_step();
        @(posedge clk);
        #1;
        key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        clr = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        for (int i = 0; i < 2; i++)
            step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", snap(), ev(0, 16'h0000));
        end
        clr = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", snap(), ev(0, 16'h0000));
        end
    endtask

    task automatic test_entry();
        int keys[6] = '{1, 2, 3, 0, 7, 11};
        do_reset();
        step(1, 4'(keys[0]), 0, 0, 0, 0);
        checks++;
        if (snap() !== ev(1, 16'h0001)) begin
            errors++;
            $display("FAIL entry_first: got %h expected %h", snap(), ev(1, 16'h0001));
        end
        for (int i = 1; i < 6; i++) step(1, 4'(keys[i]), 0, 0, 0, 0);
        checks++;
        if (snap() !== ev(1, 16'h1230)) begin
            errors++;
            $display("FAIL entry_saturate: got %h expected %h", snap(), ev(1, 16'h1230));
        end
    endtask

    task automatic test_countdown();
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (snap() !== ev(2, 16'h0100)) begin
            errors++;
            $display("FAIL cd_start: got %h expected %h", snap(), ev(2, 16'h0100));
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (snap() !== ev(2, 16'h0059)) begin
            errors++;
            $display("FAIL cd_borrow: got %h expected %h", snap(), ev(2, 16'h0059));
        end
        for (int i = 0; i < 29; i++) step(0, 0, 0, 0, 0, 1);
        checks++;
        if (snap() !== ev(2, 16'h0030)) begin
            errors++;
            $display("FAIL cd_mid: got %h expected %h", snap(), ev(2, 16'h0030));
        end
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 1);
        checks++;
        if (snap() !== ev(4, 16'h0000)) begin
            errors++;
            $display("FAIL cd_done: got %h expected %h", snap(), ev(4, 16'h0000));
        end
    endtask

    task automatic test_door_pause();
        do_reset();
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (snap() !== ev(3, 16'h0005)) begin
            errors++;
            $display("FAIL door_pause: got %h expected %h", snap(), ev(3, 16'h0005));
        end
        step(0, 0, 1, 0, 1, 0);
        checks++;
        if (snap() !== ev(3, 16'h0005)) begin
            errors++;
            $display("FAIL door_start_open: got %h expected %h", snap(), ev(3, 16'h0005));
        end
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (snap() !== ev(2, 16'h0004)) begin
            errors++;
            $display("FAIL door_resume: got %h expected %h", snap(), ev(2, 16'h0004));
        end
    endtask

    task automatic test_priority();
        do_reset();
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL prio_stop_over_start: got %h expected %h", snap(), ev(0, 16'h0000));
        end
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL prio_start_zero: got %h expected %h", snap(), ev(0, 16'h0000));
        end
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (snap() !== ev(3, 16'h0002)) begin
            errors++;
            $display("FAIL prio_run_stop: got %h expected %h", snap(), ev(3, 16'h0002));
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL prio_pause_clear: got %h expected %h", snap(), ev(0, 16'h0000));
        end
    endtask

    task automatic test_done_hold();
        do_reset();
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < HOLD; i++) begin
            checks++;
            if (snap() !== ev(4, 16'h0000)) begin
                errors++;
                $display("FAIL done_hold_%0d: got %h expected %h", i, snap(), ev(4, 16'h0000));
            end
            step(0, 0, 0, 0, 0, 1);
        end
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL done_expire: got %h expected %h", snap(), ev(0, 16'h0000));
        end
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 7, 0, 0, 0, 0);
        checks++;
        if (snap() !== ev(0, 16'h0000)) begin
            errors++;
            $display("FAIL done_key_exit: got %h expected %h", snap(), ev(0, 16'h0000));
        end
        step(1, 4, 0, 0, 0, 0);
        checks++;
        if (snap() !== ev(1, 16'h0004)) begin
            errors++;
            $display("FAIL done_reentry: got %h expected %h", snap(), ev(1, 16'h0004));
        end
    endtask

    task automatic test_random();
        logic dr;
        dr = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) dr = ~dr;
            step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 11)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 dr, $urandom_range(0, 1) == 0);
            checks++;
            if (snap() !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, snap(), model_vec());
            end
        end
        clr = 1'b1;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_door_pause();
        test_priority();
        test_done_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_entry_ctrl.md
Name: timer_entry_ctrl

Overview:
Controls the microwave timer-input path. Collects keypad digits into a 4-digit BCD MM:SS register, starts and pauses the countdown, and drives the magnetron enable. Decrements once per externally supplied one-second tick and flags completion. Sits between the keypad decoder / second prescaler and the display / power stage.

Parameters:
NUM_DIGITS, 4, BCD digits held in the time register (fixed MM:SS layout).
DONE_HOLD, 3, sec_tick pulses that done stays high before returning to IDLE (range 1-7).

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-low reset (0 = reset, 1 = run)
key_valid  input  1  one-cycle pulse, key_digit valid
key_digit  input  4  keypad value; only 0-9 accepted
start  input  1  one-cycle start/resume request
stop_clear  input  1  one-cycle pause/cancel request
door_open  input  1  level, 1 = door open
sec_tick  input  1  one-cycle pulse per second from prescaler
min_tens  output  4  BCD digit 3
min_ones  output  4  BCD digit 2
sec_tens  output  4  BCD digit 1
sec_ones  output  4  BCD digit 0
magnetron_on  output  1  high only in RUN
done  output  1  high only in DONE
state  output  3  current FSM state, debug/display

Behaviour:
- Reset (clr=0 at an edge): all digits 0, state IDLE, magnetron_on 0, done 0, entry count 0, hold count 0. Reset overrides everything, including mid-RUN.
- States (3-bit encoding): IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4. All outputs are registered. magnetron_on and done are decoded from the registered state, so they change in the same cycle as state.
- Digit entry (IDLE/ENTRY only):
  - key_valid with key_digit<=9 and entry count<4 shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - Entry count increments, saturating at 4. Further digits are ignored.
  - key_digit>9 is ignored.
  - The first accepted digit moves IDLE->ENTRY.
  - Keys in RUN and PAUSE are ignored.
- Priority per cycle: stop_clear > start > key_valid.
- IDLE/ENTRY transitions:
  - stop_clear: digits and entry count cleared, ->IDLE.
  - start: ->RUN next edge only if time != 0000 and door_open=0; otherwise ignored.
- RUN transitions:
  - door_open=1 or stop_clear: ->PAUSE. Any sec_tick in the same cycle is dropped.
  - Otherwise sec_tick performs a BCD decrement of MM:SS:
    - sec_ones>0: sec_ones-1.
    - Else sec_tens>0: sec_tens-1, sec_ones=9.
    - Else (seconds are 00) borrow from minutes: seconds=59, minutes are BCD-decremented (min_ones 0 -> 9 with min_tens-1).
  - Seconds entries of 60-99 are legal and simply count down as entered (e.g. 0:99 runs 99 s).
  - If the decrement result is 0000, the same edge moves to DONE and clears the hold counter.
- PAUSE transitions:
  - start with door_open=0: ->RUN.
  - stop_clear: clear digits and entry count, ->IDLE.
  - Digits are held.
- DONE:
  - Each sec_tick increments the hold counter. When it reaches DONE_HOLD, ->IDLE and entry count resets.
  - key_valid, start or stop_clear: ->IDLE immediately. The key is not consumed.
- Time 0000 is never held in RUN.

Decomposition:
- Shared package timer_pkg:
  - State encodings.
  - BCD_MAX=9 and SEC_TENS_WRAP=5 constants.
  - Entry-count width (3 bits).
- Sub-module bcd_time_reg:
  - Holds the four digits.
  - Inputs: shift_en+digit, dec_en, zero_clr.
  - Outputs: the digits plus is_zero and next_is_zero flags.
- The FSM, entry counter and hold counter stay in timer_entry_ctrl.

Test Plan:
- Reset: hold clr=0 for 2 cycles with random inputs -> all digits 0, state=0, magnetron_on=0, done=0. Release clr=1 -> no change without stimulus.
- Entry/saturation: keys 1,2,3,0,7 then key 11 -> display 12:30; 5th key and invalid key ignored; state=ENTRY.
- Countdown with borrow: enter 1,0,0 (1:00), start -> RUN next edge, magnetron_on=1. First sec_tick -> 0:59; 59 more ticks -> 0:00, state=DONE, magnetron_on=0, done=1.
- Door/pause: RUN at 0:05, door_open=1 on the same cycle as sec_tick -> PAUSE, time stays 0:05. start while door open -> ignored. Door closed + start -> RUN; next tick -> 0:04.
- Priority and cancel:
  - start+stop_clear together in ENTRY -> IDLE, digits 0000.
  - start with 0000 -> stays IDLE.
  - stop_clear in PAUSE -> IDLE, cleared.
- DONE hold: DONE_HOLD=3 -> done high through 3 sec_ticks, IDLE on the edge of the 3rd. A second run where a key is pressed in DONE -> IDLE immediately, digits unchanged by that key.
